// File: rtl/segre_pkg.sv
// Shared fetch-path definitions: machine widths, the canonical NOP, and the
// {instr, pc} pair carried from IF to ID.
package segre_pkg;

  localparam int unsigned WORD_SIZE         = 32;
  localparam int unsigned ADDR_SIZE         = 32;
  localparam int unsigned FETCH_QUEUE_DEPTH = 4;

  // addi x0, x0, 0
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [ADDR_SIZE-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/segre_fetch_queue.sv
// Circular instruction buffer between IF and ID. Holds fetched {instr, pc}
// pairs, presents the oldest one, and supports flush, pop blocking and NOP injection.
module segre_fetch_queue
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH   = FETCH_QUEUE_DEPTH,
  parameter int unsigned INSTR_W = WORD_SIZE,
  parameter int unsigned PC_W    = ADDR_SIZE,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rsn_i,

  input  logic               push_valid_i,
  output logic               push_ready_o,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic [PC_W-1:0]    push_pc_i,

  input  logic               flush_i,
  input  logic               block_i,
  input  logic               inject_nop_i,
  input  logic               pop_i,

  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t             entries_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  logic               empty;
  logic               full;
  logic               push_fire;
  logic               pop_fire;
  entry_t             head;

  // Status depends only on registered state, so IF never sees a path from pop_i.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CNT_W'(DEPTH));
    push_ready_o = rsn_i && !full;
    valid_o      = !empty && !inject_nop_i;
    push_fire    = push_valid_i && push_ready_o && !flush_i;
    pop_fire     = pop_i && valid_o && !block_i && !flush_i;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      entries_q[wr_ptr_q] <= '{instr: push_instr_i, pc: push_pc_i};
    end
  end

  always_comb begin
    head    = entries_q[rd_ptr_q];
    instr_o = valid_o ? head.instr : INSTR_W'(NOP_INSTR);
    pc_o    = valid_o ? head.pc    : '0;
    count_o = count_q;
    empty_o = empty;
    full_o  = full;
  end

endmodule

// File: tb/tb_segre_fetch_queue.sv
// Bench for segre_fetch_queue: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_segre_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_instr_i;
  logic [31:0] push_pc_i;
  logic        flush_i;
  logic        block_i;
  logic        inject_nop_i;
  logic        pop_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [2:0]  count_o;
  logic        empty_o;
  logic        full_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];

  segre_fetch_queue dut (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .push_valid_i(push_valid_i),
    .push_ready_o(push_ready_o),
    .push_instr_i(push_instr_i),
    .push_pc_i   (push_pc_i),
    .flush_i     (flush_i),
    .block_i     (block_i),
    .inject_nop_i(inject_nop_i),
    .pop_i       (pop_i),
    .valid_o     (valid_o),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .count_o     (count_o),
    .empty_o     (empty_o),
    .full_o      (full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs straight from the queue contents and the current inputs.
  task automatic check_model();
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    if (!rsn_i) mq.delete();
    e_valid = (mq.size() != 0) && !inject_nop_i;
    e_instr = e_valid ? mq[0].instr : 32'h13;
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    chk("model_valid", {31'b0, valid_o}, {31'b0, e_valid});
    chk("model_instr", instr_o, e_instr);
    chk("model_pc", pc_o, e_pc);
    chk("model_count", {29'b0, count_o}, 32'(mq.size()));
    chk("model_empty", {31'b0, empty_o}, {31'b0, mq.size() == 0});
    chk("model_full", {31'b0, full_o}, {31'b0, mq.size() == DEPTH});
    chk("model_ready", {31'b0, push_ready_o}, {31'b0, rsn_i && (mq.size() < DEPTH)});
  endtask

  task automatic model_update();
    bit   can_push, head_valid, do_push, do_pop;
    ent_t e;
    if (!rsn_i || flush_i) begin
      mq.delete();
    end else begin
      can_push   = mq.size() < DEPTH;
      head_valid = (mq.size() != 0) && !inject_nop_i;
      do_push    = push_valid_i && can_push;
      do_pop     = pop_i && head_valid && !block_i;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.instr = push_instr_i;
        e.pc    = push_pc_i;
        mq.push_back(e);
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk_i);
    check_model();
  endtask

  task automatic finish_cycle();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic fl,
                       input logic bl, input logic nop, input logic pp);
    push_valid_i = pv;
    push_pc_i    = pc;
    push_instr_i = pc ^ 32'h5A00_0033;
    flush_i      = fl;
    block_i      = bl;
    inject_nop_i = nop;
    pop_i        = pp;
  endtask

  task automatic cycle();
    at_neg();
    finish_cycle();
  endtask

  initial begin
    rsn_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_instr", instr_o, 32'h13);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_ready", {31'b0, push_ready_o}, 32'h0);
    chk("rst_empty", {31'b0, empty_o}, 32'h1);
    chk("rst_full", {31'b0, full_o}, 32'h0);
    chk("rst_count", {29'b0, count_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    at_neg();
    chk("rel_ready", {31'b0, push_ready_o}, 32'h1);
    finish_cycle();

    // Fill, refused fifth push, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(4 * i), 0, 0, 0, 0);
      cycle();
    end
    drive(1, 32'h10, 0, 0, 0, 1);
    at_neg();
    chk("fill_full", {31'b0, full_o}, 32'h1);
    chk("fill_ready", {31'b0, push_ready_o}, 32'h0);
    chk("fill_count", {29'b0, count_o}, 32'h4);
    chk("fill_head", pc_o, 32'h0);
    finish_cycle();
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      at_neg();
      chk("drain_pc", pc_o, 32'(4 * i));
      finish_cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    at_neg();
    chk("drain_empty", {31'b0, empty_o}, 32'h1);
    finish_cycle();

    // Steady stream: one in, one out every cycle
    drive(1, 32'h100, 0, 0, 0, 0);
    cycle();
    for (int k = 1; k <= 10; k++) begin
      drive(1, 32'h100 + 32'(4 * k), 0, 0, 0, 1);
      at_neg();
      chk("stream_count", {29'b0, count_o}, 32'h1);
      chk("stream_pc", pc_o, 32'h100 + 32'(4 * (k - 1)));
      finish_cycle();
    end
    drive(0, 0, 0, 0, 0, 1);
    at_neg();
    chk("stream_last", pc_o, 32'h128);
    finish_cycle();

    // Flush with a concurrent push
    drive(1, 32'h300, 0, 0, 0, 0);
    cycle();
    drive(1, 32'h304, 0, 0, 0, 0);
    cycle();
    drive(1, 32'h40, 1, 1, 0, 1);
    at_neg();
    chk("flush_pre_count", {29'b0, count_o}, 32'h2);
    finish_cycle();
    drive(1, 32'h80, 0, 0, 0, 0);
    at_neg();
    chk("flush_count", {29'b0, count_o}, 32'h0);
    chk("flush_valid", {31'b0, valid_o}, 32'h0);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 1);
    at_neg();
    chk("flush_refetch", pc_o, 32'h80);
    finish_cycle();

    // Block and NOP injection keep the head entry
    drive(1, 32'h20, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0, 1);
      at_neg();
      chk("block_pc", pc_o, 32'h20);
      chk("block_count", {29'b0, count_o}, 32'h1);
      finish_cycle();
    end
    drive(0, 0, 0, 0, 1, 1);
    at_neg();
    chk("nop_valid", {31'b0, valid_o}, 32'h0);
    chk("nop_instr", instr_o, 32'h13);
    chk("nop_count", {29'b0, count_o}, 32'h1);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 1);
    at_neg();
    chk("nop_release_valid", {31'b0, valid_o}, 32'h1);
    chk("nop_release_pc", pc_o, 32'h20);
    finish_cycle();

    // Pop on empty with a simultaneous push
    drive(1, 32'h200, 0, 0, 0, 1);
    at_neg();
    chk("epop_empty", {31'b0, empty_o}, 32'h1);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 1);
    at_neg();
    chk("epop_count", {29'b0, count_o}, 32'h1);
    chk("epop_pc", pc_o, 32'h200);
    finish_cycle();

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h500 + 32'(4 * i), 0, 0, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    at_neg();
    chk("mid_pre_count", {29'b0, count_o}, 32'h3);
    model_update();
    #1 rsn_i = 1'b0;
    #1;
    chk("mid_valid", {31'b0, valid_o}, 32'h0);
    chk("mid_instr", instr_o, 32'h13);
    chk("mid_count", {29'b0, count_o}, 32'h0);
    chk("mid_ready", {31'b0, push_ready_o}, 32'h0);
    mq.delete();
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    at_neg();
    chk("mid_rel_ready", {31'b0, push_ready_o}, 32'h1);
    finish_cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rsn_i        = ($urandom_range(0, 199) != 0);
      push_valid_i = ($urandom_range(0, 9) < 7);
      push_pc_i    = $urandom;
      push_instr_i = $urandom;
      pop_i        = ($urandom_range(0, 9) < 6);
      block_i      = ($urandom_range(0, 19) < 3);
      inject_nop_i = ($urandom_range(0, 9) == 0);
      flush_i      = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/segre_fetch_queue.md
Name: segre_fetch_queue

Overview:
Decoupling instruction buffer between the fetch stage and the decode stage. It accepts fetched {instr, pc} pairs on cache hit, holds up to DEPTH entries, and presents the oldest to ID. Decode can stall without re-fetching. A taken branch from WB flushes all wrong-path entries, and the controller can block pops or force a NOP bubble into ID.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
INSTR_W, WORD_SIZE (32), instruction width
PC_W, ADDR_SIZE (32), PC width
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk_i  in  1  clock, rising edge
rsn_i  in  1  asynchronous active-low reset
push_valid_i  in  1  IF presents a valid fetched instruction (cache hit)
push_ready_o  out  1  queue can accept this cycle (registered-state only, no comb path from pop)
push_instr_i  in  INSTR_W  fetched instruction
push_pc_i  in  PC_W  PC of fetched instruction
flush_i  in  1  taken branch (tkbr) from WB; discard contents
block_i  in  1  controller stall of ID; suppresses pop
inject_nop_i  in  1  controller forces NOP toward ID
pop_i  in  1  ID consumes head entry
valid_o  out  1  instr_o/pc_o carry a real instruction
instr_o  out  INSTR_W  head instruction, or NOP_INSTR
pc_o  out  PC_W  head PC, or 0 when no valid entry
count_o  out  CNT_W  current occupancy
empty_o  out  1  count_o == 0
full_o  out  1  count_o == DEPTH

Behaviour:
- State: entry array, rd_ptr and wr_ptr (log2(DEPTH) bits, wrap mod DEPTH), count (CNT_W bits).
- Reset (rsn_i low, async): pointers = 0, count = 0. Outputs while in reset: valid_o = 0, instr_o = NOP_INSTR, pc_o = 0, push_ready_o = 0, empty_o = 1, full_o = 0. Entry array contents are don't-care.
- push_ready_o = rsn_i && !full_o. A full queue refuses a push even if a pop occurs in the same cycle.
- push_fire = push_valid_i && push_ready_o && !flush_i.
  - Writes entry[wr_ptr] and increments wr_ptr at the clock edge.
  - Latency: the entry is visible on outputs the next cycle; there is no empty-queue bypass.
- pop_fire = pop_i && valid_o && !block_i && !flush_i.
  - Increments rd_ptr.
  - pop_i while valid_o = 0 is ignored; no underflow.
- Count update (push_fire, pop_fire):
  - (1,0): +1
  - (0,1): -1
  - (1,1): unchanged; both pointers advance.
- Output mux:
  - valid_o = !empty_o && !inject_nop_i.
  - When valid_o = 1: instr_o = entry[rd_ptr], pc_o = entry[rd_ptr].pc.
  - Otherwise: instr_o = NOP_INSTR, pc_o = 0.
  - inject_nop_i never pops, so the head entry is preserved.
- Flush:
  - flush_i in cycle N sets rd_ptr = wr_ptr = 0 and count = 0 at edge N.
  - A concurrent push is dropped; IF re-fetches from the new PC starting cycle N+1.
  - Outputs during cycle N are still driven from the current state; ID must treat them as squashed.
- Simultaneous flush_i and block_i: flush wins.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

Decomposition:
- segre_pkg: NOP_INSTR = 32'h0000_0013 (addi x0,x0,0), FETCH_QUEUE_DEPTH = 4, and typedef fetch_entry_t (packed struct {instr, pc}).
- The block is flat; a sub-module is not warranted.
- segre_if_stage drives push_*. Its stall condition becomes !push_ready_o.

Test Plan:
- Reset mid-traffic: 3 entries queued, rsn_i pulsed low -> same cycle valid_o=0, instr_o=32'h13, count_o=0, push_ready_o=0; after release, push_ready_o=1.
- Fill/drain: push PCs 0x0,0x4,0x8,0xC with pop_i=0 -> full_o=1, push_ready_o=0, a 5th push (0x10) is dropped. Then pop 4 cycles -> pc_o sequence 0x0,0x4,0x8,0xC, then empty_o=1.
- Steady stream: push and pop every cycle for 10 cycles (PC 0x100 + 4k) -> count_o stays 1, pc_o lags push by exactly one cycle, pointers wrap twice with no lost entry.
- Flush with concurrent push: count=2, flush_i=1 with push_pc_i=0x40 -> next cycle count_o=0, valid_o=0. A push of 0x80 the following cycle appears as pc_o=0x80.
- Stall/NOP: count=1 (pc 0x20). block_i=1 with pop_i=1 for 2 cycles -> pc_o stays 0x20, count_o=1. Then inject_nop_i=1 -> valid_o=0, instr_o=32'h13, entry retained; deassert -> valid_o=1, pc_o=0x20.
- Empty pop: pop_i=1 with empty queue and simultaneous push of 0x200 -> no underflow; next cycle count_o=1, pc_o=0x200.
